// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the register slave: bus widths, response codes, FSM states.
// Optional build macro used by the slave: AXIL_SLAVE_WSTRB_EN (byte-lane write strobes).
package axi_lite_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface axi_lite_if;
    import axi_lite_pkg::*;

    addr_t s_axi_awaddr;
    logic  s_axi_awvalid;
    logic  s_axi_awready;

    data_t s_axi_wdata;
    strb_t s_axi_wstrb;
    logic  s_axi_wvalid;
    logic  s_axi_wready;

    resp_t s_axi_bresp;
    logic  s_axi_bvalid;
    logic  s_axi_bready;

    addr_t s_axi_araddr;
    logic  s_axi_arvalid;
    logic  s_axi_arready;

    data_t s_axi_rdata;
    resp_t s_axi_rresp;
    logic  s_axi_rvalid;
    logic  s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, input s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid, input s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid, output s_axi_bready,
        output s_axi_araddr, s_axi_arvalid, input s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid, output s_axi_rready
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid, output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid, input s_axi_bready,
        input  s_axi_araddr, s_axi_arvalid, output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid, input s_axi_rready
    );

endinterface

// File: rtl/axi_lite_regfile.sv
// NUM_REGS x 32-bit register storage: one byte-enabled write port, one combinational read port.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  data_t            wr_data,
    input  strb_t            wr_be,
    input  logic [IDX_W-1:0] rd_idx,
    output data_t            rd_data
);

    data_t regs_q [NUM_REGS];
    data_t regs_d [NUM_REGS];

    // Indices beyond NUM_REGS only arise for non-power-of-two sizes and are ignored.
    always_comb begin
        regs_d = regs_q;
        if (we && (int'(wr_idx) < NUM_REGS)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = (int'(rd_idx) < NUM_REGS) ? regs_q[rd_idx] : '0;
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers at BASE_ADDR; independent read/write FSMs.
// Build option: define AXIL_SLAVE_WSTRB_EN to honour wstrb byte lanes (default writes all 32 bits).
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int    NUM_REGS  = 4,
    parameter addr_t BASE_ADDR = 32'h0
) (
    input  logic        aclk,
    input  logic        areset,
    axi_lite_if.slave   s_axi_lite
);

    localparam int    IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam addr_t SPAN  = addr_t'(4 * NUM_REGS);

    w_state_t w_state_q, w_state_d;
    addr_t    aw_addr_q, aw_addr_d;
    data_t    w_data_q, w_data_d;
    strb_t    w_strb_q, w_strb_d;
    resp_t    bresp_q, bresp_d;

    r_state_t r_state_q, r_state_d;
    data_t    rdata_q, rdata_d;
    resp_t    rresp_q, rresp_d;

    addr_t            wr_addr, wr_off, rd_off;
    data_t            wr_data, rd_data;
    strb_t            wr_strb, wr_be;
    logic             wr_hit, rd_hit, wr_commit, wr_en;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    // The write target comes from whichever half of the transfer was captured earlier.
    always_comb begin
        wr_addr = (w_state_q == W_HAVE_ADDR) ? aw_addr_q : s_axi_lite.s_axi_awaddr;
        wr_data = (w_state_q == W_HAVE_DATA) ? w_data_q  : s_axi_lite.s_axi_wdata;
        wr_strb = (w_state_q == W_HAVE_DATA) ? w_strb_q  : s_axi_lite.s_axi_wstrb;
        wr_off  = wr_addr - BASE_ADDR;
        wr_hit  = (wr_addr >= BASE_ADDR) && (wr_off < SPAN);
        wr_idx  = wr_off[IDX_W+1:2];
        rd_off  = s_axi_lite.s_axi_araddr - BASE_ADDR;
        rd_hit  = (s_axi_lite.s_axi_araddr >= BASE_ADDR) && (rd_off < SPAN);
        rd_idx  = rd_off[IDX_W+1:2];
    end

`ifdef AXIL_SLAVE_WSTRB_EN
    assign wr_be = wr_strb;
`else
    logic unused_strb;
    assign unused_strb = ^wr_strb;
    assign wr_be       = 4'hF;
`endif

    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bresp_d   = bresp_q;
        wr_commit = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_lite.s_axi_awvalid && s_axi_lite.s_axi_wvalid) begin
                    wr_commit = 1'b1;
                end else if (s_axi_lite.s_axi_awvalid) begin
                    aw_addr_d = s_axi_lite.s_axi_awaddr;
                    w_state_d = W_HAVE_ADDR;
                end else if (s_axi_lite.s_axi_wvalid) begin
                    w_data_d  = s_axi_lite.s_axi_wdata;
                    w_strb_d  = s_axi_lite.s_axi_wstrb;
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: wr_commit = s_axi_lite.s_axi_wvalid;
            W_HAVE_DATA: wr_commit = s_axi_lite.s_axi_awvalid;
            W_RESP: begin
                if (s_axi_lite.s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (wr_commit) begin
            bresp_d   = wr_hit ? OKAY : SLVERR;
            w_state_d = W_RESP;
        end
    end

    assign wr_en = wr_commit && wr_hit && !areset;

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_lite.s_axi_arvalid) begin
                    rdata_d   = rd_hit ? rd_data : '0;
                    rresp_d   = rd_hit ? OKAY : SLVERR;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_lite.s_axi_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= OKAY;
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Outputs are forced quiet combinationally so the bus is idle for the whole reset window.
    assign s_axi_lite.s_axi_awready = !areset && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_DATA));
    assign s_axi_lite.s_axi_wready  = !areset && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_ADDR));
    assign s_axi_lite.s_axi_bvalid  = !areset && (w_state_q == W_RESP);
    assign s_axi_lite.s_axi_bresp   = areset ? OKAY : bresp_q;
    assign s_axi_lite.s_axi_arready = !areset && (r_state_q == R_IDLE);
    assign s_axi_lite.s_axi_rvalid  = !areset && (r_state_q == R_DATA);
    assign s_axi_lite.s_axi_rdata   = areset ? '0 : rdata_q;
    assign s_axi_lite.s_axi_rresp   = areset ? OKAY : rresp_q;

    axi_lite_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk     (aclk),
        .rst     (areset),
        .we      (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: directed scenarios plus randomized traffic vs. an array model.
// Follows AXIL_SLAVE_WSTRB_EN to decide whether the model honours byte strobes.
module tb_axi_lite_slave_regs;
    import axi_lite_pkg::*;

    localparam int    NUM_REGS  = 4;
    localparam addr_t BASE_ADDR = 32'h0;
`ifdef AXIL_SLAVE_WSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic  aclk;
    logic  areset;
    int    checks;
    int    failures;
    data_t model [NUM_REGS];
    data_t old_val;

    axi_lite_if axi ();

    axi_lite_slave_regs #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_axi_lite (axi)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        axi.s_axi_awaddr  = '0;
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata   = '0;
        axi.s_axi_wstrb   = '0;
        axi.s_axi_wvalid  = 1'b0;
        axi.s_axi_bready  = 1'b0;
        axi.s_axi_araddr  = '0;
        axi.s_axi_arvalid = 1'b0;
        axi.s_axi_rready  = 1'b0;
    endtask

    function automatic bit exp_hit(input addr_t a);
        longint aa = longint'(a);
        return (aa >= longint'(BASE_ADDR)) && (aa < longint'(BASE_ADDR) + 4 * NUM_REGS);
    endfunction

    function automatic int exp_idx(input addr_t a);
        return int'((a - BASE_ADDR) / 4);
    endfunction

    task automatic model_write(input addr_t a, input data_t d, input strb_t s);
        if (exp_hit(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (!STRB_EN || s[b]) model[exp_idx(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic axi_write(input addr_t a, input data_t d, input strb_t s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit    aw_done, w_done, aw_hs, w_hs;
        int    cyc;
        resp_t exp_resp;
        exp_resp = exp_hit(a) ? OKAY : SLVERR;
        aw_done = 0;
        w_done  = 0;
        cyc     = 0;
        axi.s_axi_awaddr = a;
        axi.s_axi_wdata  = d;
        axi.s_axi_wstrb  = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            axi.s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            axi.s_axi_wvalid  = !w_done && (cyc >= w_dly);
            aw_hs = axi.s_axi_awvalid && axi.s_axi_awready;
            w_hs  = axi.s_axi_wvalid && axi.s_axi_wready;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            cyc++;
        end
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            checks++;
            failures++;
            $error("[TB] FAIL write_timeout addr=%h observed=no_handshake expected=handshake", a);
        end
        model_write(a, d, s);
        for (int i = 0; i < b_dly; i++) begin
            checkOutput("bvalid_held", axi.s_axi_bvalid, 1'b1);
            checkOutput("bresp_held", axi.s_axi_bresp, exp_resp);
            checkOutput("no_aw_in_resp", axi.s_axi_awready, 1'b0);
            tick();
        end
        checkOutput("bvalid", axi.s_axi_bvalid, 1'b1);
        checkOutput("bresp", axi.s_axi_bresp, exp_resp);
        checkOutput("no_w_in_resp", axi.s_axi_wready, 1'b0);
        axi.s_axi_bready = 1'b1;
        tick();
        axi.s_axi_bready = 1'b0;
        checkOutput("bvalid_drop", axi.s_axi_bvalid, 1'b0);
    endtask

    task automatic axi_read(input addr_t a, input int r_dly);
        int    cyc;
        data_t exp_data;
        resp_t exp_resp;
        exp_data = exp_hit(a) ? model[exp_idx(a)] : 32'h0;
        exp_resp = exp_hit(a) ? OKAY : SLVERR;
        axi.s_axi_araddr  = a;
        axi.s_axi_arvalid = 1'b1;
        cyc = 0;
        while (!axi.s_axi_arready && cyc < 40) begin
            tick();
            cyc++;
        end
        if (cyc >= 40) begin
            checks++;
            failures++;
            $error("[TB] FAIL read_timeout addr=%h observed=no_arready expected=arready", a);
        end
        checkOutput("rvalid_before_ar", axi.s_axi_rvalid, 1'b0);
        tick();
        axi.s_axi_arvalid = 1'b0;
        for (int i = 0; i < r_dly; i++) begin
            checkOutput("rvalid_held", axi.s_axi_rvalid, 1'b1);
            checkOutput("rdata_held", axi.s_axi_rdata, exp_data);
            checkOutput("no_ar_in_data", axi.s_axi_arready, 1'b0);
            tick();
        end
        checkOutput("rvalid", axi.s_axi_rvalid, 1'b1);
        checkOutput("rdata", axi.s_axi_rdata, exp_data);
        checkOutput("rresp", axi.s_axi_rresp, exp_resp);
        axi.s_axi_rready = 1'b1;
        tick();
        axi.s_axi_rready = 1'b0;
        checkOutput("rvalid_drop", axi.s_axi_rvalid, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, "_awready"}, axi.s_axi_awready, 1'b0);
        checkOutput({tag, "_wready"},  axi.s_axi_wready,  1'b0);
        checkOutput({tag, "_arready"}, axi.s_axi_arready, 1'b0);
        checkOutput({tag, "_bvalid"},  axi.s_axi_bvalid,  1'b0);
        checkOutput({tag, "_rvalid"},  axi.s_axi_rvalid,  1'b0);
        checkOutput({tag, "_rdata"},   axi.s_axi_rdata,   32'h0);
    endtask

    initial begin
        addr_t a;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        applyStimulus();
        areset = 1'b1;
        #1;
        check_quiet("reset");
        tick();
        tick();
        check_quiet("reset_hold");
        areset = 1'b0;
        tick();
        checkOutput("idle_awready", axi.s_axi_awready, 1'b1);
        checkOutput("idle_wready",  axi.s_axi_wready,  1'b1);
        checkOutput("idle_arready", axi.s_axi_arready, 1'b1);
        checkOutput("idle_bvalid",  axi.s_axi_bvalid,  1'b0);

        $display("[TB] same-cycle AW/W write then read");
        axi_write(32'h4, 32'hdeadbeef, 4'hF, 0, 0, 0);
        axi_read(32'h4, 0);

        $display("[TB] W three cycles before AW, bready held low");
        axi_write(32'h8, 32'h12345678, 4'hF, 3, 0, 2);
        axi_read(32'h8, 1);

        $display("[TB] out-of-range access");
        axi_write(32'h40, 32'hcafef00d, 4'hF, 0, 1, 0);
        axi_read(32'h40, 0);
        for (int i = 0; i < NUM_REGS; i++) axi_read(BASE_ADDR + addr_t'(4 * i), 0);

        $display("[TB] write strobes");
`ifdef AXIL_SLAVE_WSTRB_EN
        axi_write(32'h0, 32'hffffffff, 4'hF, 0, 0, 0);
        axi_write(32'h0, 32'h00000000, 4'b0011, 0, 0, 0);
        axi_read(32'h0, 0);
        axi_write(32'h0, 32'h00000000, 4'b0000, 1, 0, 0);
        axi_read(32'h0, 0);
`else
        axi_write(32'h0, 32'ha5a5a5a5, 4'b0000, 0, 0, 0);
        axi_read(32'h0, 0);
`endif

        $display("[TB] AR in the same cycle as a write commit");
        axi_write(32'h4, 32'h0, 4'hF, 0, 0, 0);
        old_val = model[1];
        axi.s_axi_awaddr  = 32'h4;
        axi.s_axi_wdata   = 32'h1;
        axi.s_axi_wstrb   = 4'hF;
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wvalid  = 1'b1;
        axi.s_axi_araddr  = 32'h4;
        axi.s_axi_arvalid = 1'b1;
        tick();
        applyStimulus();
        model_write(32'h4, 32'h1, 4'hF);
        checkOutput("conc_bvalid", axi.s_axi_bvalid, 1'b1);
        checkOutput("conc_rvalid", axi.s_axi_rvalid, 1'b1);
        checkOutput("conc_rdata_old", axi.s_axi_rdata, old_val);
        axi.s_axi_bready = 1'b1;
        axi.s_axi_rready = 1'b1;
        tick();
        applyStimulus();
        axi_read(32'h4, 0);

        $display("[TB] reset while holding an address");
        axi_write(32'hC, 32'h77777777, 4'hF, 0, 0, 0);
        axi.s_axi_awaddr  = 32'hC;
        axi.s_axi_awvalid = 1'b1;
        tick();
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata   = 32'h55555555;
        axi.s_axi_wstrb   = 4'hF;
        axi.s_axi_wvalid  = 1'b1;
        areset = 1'b1;
        #1;
        check_quiet("midreset");
        tick();
        check_quiet("midreset_hold");
        axi.s_axi_wvalid = 1'b0;
        areset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_reset_bvalid", axi.s_axi_bvalid, 1'b0);
        end
        for (int i = 0; i < NUM_REGS; i++) axi_read(BASE_ADDR + addr_t'(4 * i), 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0)
                a = BASE_ADDR + addr_t'(4 * NUM_REGS) + addr_t'($urandom_range(0, 255));
            else
                a = BASE_ADDR + addr_t'(4 * $urandom_range(0, NUM_REGS - 1)) + addr_t'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, strb_t'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 2));
        end
        for (int i = 0; i < NUM_REGS; i++) axi_read(BASE_ADDR + addr_t'(4 * i), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4: number of 32-bit registers, legal range 1..64.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0: byte address of register 0, 4-byte aligned.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port aclk, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port areset, input, 1: synchronous active-high reset.
REQ-006 SHALL have port s_axi_lite, axi_lite_if.slave modport: AW/W/B/AR/R channels, s_axi_* signals, 32-bit addr/data.

Function
REQ-007 SHALL decode address as in-range iff BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS; index = (addr-BASE_ADDR)>>2; addr[1:0] ignored.
REQ-008 SHALL run write FSM W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP; awready high in W_IDLE/W_HAVE_DATA; wready high in W_IDLE/W_HAVE_ADDR.
REQ-009 SHALL accept AW and W in either order or in the same cycle; both in same cycle goes W_IDLE -> W_RESP directly.
REQ-010 SHALL commit the register write on the clock edge that completes the second of the AW/W handshakes.
REQ-011 SHALL assert bvalid in W_RESP, the cycle after commit, held with stable bresp until bready; then W_IDLE.
REQ-012 SHALL give bresp OKAY (2'b00) in range; out of range SLVERR (2'b10) with no register modified.
REQ-013 SHALL run read FSM R_IDLE (arready=1), R_DATA (rvalid=1); AR handshake registers rdata/rresp and moves to R_DATA.
REQ-014 SHALL assert rvalid exactly one cycle after the AR handshake, holding rdata/rresp stable until rready; then R_IDLE.
REQ-015 SHALL return rdata 0 with rresp SLVERR for out-of-range reads; OKAY otherwise.
REQ-016 SHALL run read and write FSMs independently and concurrently.
REQ-017 SHALL return the pre-write value when an AR handshake and a write commit hit the same register in the same cycle.
REQ-018 SHALL accept no new AW/W while in W_RESP and no new AR while in R_DATA.

Reset
REQ-019 SHALL, while areset is high, drive awready, wready, arready, bvalid, rvalid to 0 and bresp, rresp, rdata to 0.
REQ-020 SHALL clear all registers to 0 and both FSMs to idle on reset.
REQ-021 SHALL, on reset mid-transaction, abandon it: no register write, no B or R response issued afterwards.

Configuration
REQ-022 SHALL honour macro AXIL_SLAVE_WSTRB_EN: when defined, byte lane i is written only if wstrb[i]=1, and all-zero wstrb writes nothing but still returns OKAY.
REQ-023 SHALL, when AXIL_SLAVE_WSTRB_EN is undefined, ignore wstrb and write all 32 bits.

Structure
REQ-024 SHALL take addr_t, data_t and resp_t from axi_lite_pkg; resp_t enum (OKAY=2'b00, SLVERR=2'b10) SHALL be added there.
REQ-025 SHALL place storage in sub-module axi_lite_regfile: one write port with byte enables, one combinational read port, NUM_REGS parameter.
REQ-026 SHALL keep both FSMs, address decode and response logic in axi_lite_slave_regs.

Verification
REQ-027 SHALL cover: AW and W in the same cycle, addr 32'h4, data 32'hdeadbeef -> bvalid next cycle, OKAY; then read 32'h4 -> rvalid one cycle after AR, rdata 32'hdeadbeef, OKAY.
REQ-028 SHALL cover: W 3 cycles before AW (addr 32'h8, data 32'h12345678), bready low 2 cycles -> bvalid/bresp held; read 32'h8 returns 32'h12345678.
REQ-029 SHALL cover: write and read at 32'h40 (NUM_REGS=4) -> bresp SLVERR, rdata 0, rresp SLVERR, registers unchanged.
REQ-030 SHALL cover, with AXIL_SLAVE_WSTRB_EN: reg0=32'hffffffff, write 32'h0 with wstrb 4'b0011 -> read 32'hffff0000; without the macro, wstrb 4'b0000 with data 32'ha5a5a5a5 -> read 32'ha5a5a5a5.
REQ-031 SHALL cover: AR to reg1 in the same cycle as a write commit of 32'h1 to reg1 (old 32'h0) -> rdata 32'h0; a following read returns 32'h1.
REQ-032 SHALL cover: areset asserted in W_HAVE_ADDR -> readys/valids 0 during reset, no bvalid afterwards, all reads return 0.
